// File: rtl/vscale_mem_arbiter_if.sv
// vscale_mem_arbiter_if
// Bundles the three sides of the memory arbiter: the imem (fetch) requester,
// the dmem (load/store) requester and the shared pipelined memory port.
//   slave  : the arbiter's view. It takes requests and memory responses in,
//            and drives the muxed request and the routed responses out.
//   master : the environment's view, which drives requests and memory responses.
interface vscale_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  imem_en;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic                  imem_wait;
  logic [DATA_WIDTH-1:0] imem_rdata;
  logic                  imem_badmem_e;

  logic                  dmem_en;
  logic                  dmem_wen;
  logic [2:0]            dmem_size;
  logic [ADDR_WIDTH-1:0] dmem_addr;
  logic [DATA_WIDTH-1:0] dmem_wdata_delayed;
  logic                  dmem_wait;
  logic [DATA_WIDTH-1:0] dmem_rdata;
  logic                  dmem_badmem_e;

  logic                  mem_en;
  logic                  mem_wen;
  logic [2:0]            mem_size;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_wait;
  logic                  mem_badmem_e;

  modport slave (
    input  imem_en, imem_addr,
    output imem_wait, imem_rdata, imem_badmem_e,
    input  dmem_en, dmem_wen, dmem_size, dmem_addr, dmem_wdata_delayed,
    output dmem_wait, dmem_rdata, dmem_badmem_e,
    output mem_en, mem_wen, mem_size, mem_addr, mem_wdata,
    input  mem_rdata, mem_wait, mem_badmem_e
  );

  modport master (
    output imem_en, imem_addr,
    input  imem_wait, imem_rdata, imem_badmem_e,
    output dmem_en, dmem_wen, dmem_size, dmem_addr, dmem_wdata_delayed,
    input  dmem_wait, dmem_rdata, dmem_badmem_e,
    input  mem_en, mem_wen, mem_size, mem_addr, mem_wdata,
    output mem_rdata, mem_wait, mem_badmem_e
  );
endinterface

// File: rtl/vscale_mem_arbiter.sv
// vscale_mem_arbiter
// Shares one pipelined memory port between the instruction-fetch (imem) and
// data (dmem) requesters. Address-phase arbitration and the request mux are
// combinational. A registered owner tracks the outstanding data phase, so that
// wait, read data and bus-error responses are routed back to the right requester.
// A refused requester sees its wait asserted for one cycle, and then re-presents its request.
//
// Ports:
//   clk    clock, rising edge
//   reset  asynchronous, active-low reset (0 = in reset)
//   bus    vscale_mem_arbiter_if.slave (imem_*, dmem_*, mem_* signal groups)
//
// Build option:
//   VSCALE_MEM_ARB_FAIRNESS_EN - when defined, imem wins one contest after
//   MAX_DMEM_STREAK consecutive contested dmem grants. When it is undefined,
//   dmem always has strict priority.
//
// State (per owner register)
//   value     | meaning
//   OWN_NONE  | no data phase outstanding (dp_owner only)
//   OWN_IMEM  | fetch owns the address/data phase
//   OWN_DMEM  | load/store owns the address/data phase
module vscale_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
`ifdef VSCALE_MEM_ARB_FAIRNESS_EN
  , parameter int MAX_DMEM_STREAK = 4
`endif
) (
  input  logic                clk,
  input  logic                reset,
  vscale_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IMEM = 2'd1,
    OWN_DMEM = 2'd2
  } owner_e;

  // A fetch is always a full word.
  localparam logic [2:0] IMEM_SIZE = 3'b010;

  owner_e ap_grant, ap_grant_nxt;
  owner_e dp_owner, dp_owner_nxt;
  owner_e grant;
  logic   dp_wen, dp_wen_nxt;
  logic   imem_lost, imem_lost_nxt;
  logic   dmem_lost, dmem_lost_nxt;
  logic   contest;

  logic                  en_sel;
  logic                  wen_sel;
  logic [2:0]            size_sel;
  logic [ADDR_WIDTH-1:0] addr_sel;

`ifdef VSCALE_MEM_ARB_FAIRNESS_EN
  logic [3:0] streak, streak_nxt;
`endif

  assign contest = bus.imem_en & bus.dmem_en;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ap_grant  <= OWN_IMEM;
      dp_owner  <= OWN_NONE;
      dp_wen    <= 1'b0;
      imem_lost <= 1'b0;
      dmem_lost <= 1'b0;
`ifdef VSCALE_MEM_ARB_FAIRNESS_EN
      streak    <= 4'd0;
`endif
    end else begin
      ap_grant  <= ap_grant_nxt;
      dp_owner  <= dp_owner_nxt;
      dp_wen    <= dp_wen_nxt;
      imem_lost <= imem_lost_nxt;
      dmem_lost <= dmem_lost_nxt;
`ifdef VSCALE_MEM_ARB_FAIRNESS_EN
      streak    <= streak_nxt;
`endif
    end
  end

  // While the port stalls, the address phase is frozen on the previous grant.
  // This is why a contest that arrives during a stall cannot move the grant.
  // When neither requester is active, the old grant is kept. mem_en then
  // reads that requester's inactive en.
  always_comb begin
    grant = ap_grant;
    if (!bus.mem_wait) begin
      if (contest) begin
`ifdef VSCALE_MEM_ARB_FAIRNESS_EN
        grant = (streak == 4'(MAX_DMEM_STREAK)) ? OWN_IMEM : OWN_DMEM;
`else
        grant = OWN_DMEM;
`endif
      end else if (bus.dmem_en) begin
        grant = OWN_DMEM;
      end else if (bus.imem_en) begin
        grant = OWN_IMEM;
      end
    end
  end

  always_comb begin
    en_sel   = bus.imem_en;
    wen_sel  = 1'b0;
    size_sel = IMEM_SIZE;
    addr_sel = bus.imem_addr;
    if (grant == OWN_DMEM) begin
      en_sel   = bus.dmem_en;
      wen_sel  = bus.dmem_wen;
      size_sel = bus.dmem_size;
      addr_sel = bus.dmem_addr;
    end
  end

  always_comb begin
    ap_grant_nxt  = ap_grant;
    dp_owner_nxt  = dp_owner;
    dp_wen_nxt    = dp_wen;
    imem_lost_nxt = imem_lost;
    dmem_lost_nxt = dmem_lost;
`ifdef VSCALE_MEM_ARB_FAIRNESS_EN
    streak_nxt    = streak;
`endif
    if (!bus.mem_wait) begin
      ap_grant_nxt  = grant;
      dp_owner_nxt  = en_sel ? grant : OWN_NONE;
      dp_wen_nxt    = en_sel & wen_sel;
      imem_lost_nxt = contest & (grant == OWN_DMEM);
      dmem_lost_nxt = contest & (grant == OWN_IMEM);
`ifdef VSCALE_MEM_ARB_FAIRNESS_EN
      // The streak cannot pass MAX_DMEM_STREAK, because imem wins the contest
      // that would push it over.
      if (en_sel) begin
        streak_nxt = (contest && grant == OWN_DMEM) ? streak + 4'd1 : 4'd0;
      end
`endif
    end
  end

  // During reset the request mux is still live. The request strobes are
  // gated here so that nothing escapes onto the shared port.
  assign bus.mem_en   = reset & en_sel;
  assign bus.mem_wen  = reset & wen_sel;
  assign bus.mem_size = size_sel;
  assign bus.mem_addr = addr_sel;

  assign bus.mem_wdata = (dp_owner == OWN_DMEM && dp_wen) ? bus.dmem_wdata_delayed
                                                          : '0;

  assign bus.imem_wait = imem_lost | ((dp_owner == OWN_IMEM) & bus.mem_wait);
  assign bus.dmem_wait = dmem_lost | ((dp_owner == OWN_DMEM) & bus.mem_wait);

  assign bus.imem_rdata = bus.mem_rdata;
  assign bus.dmem_rdata = bus.mem_rdata;

  assign bus.imem_badmem_e = bus.mem_badmem_e & (dp_owner == OWN_IMEM) & ~bus.mem_wait;
  assign bus.dmem_badmem_e = bus.mem_badmem_e & (dp_owner == OWN_DMEM) & ~bus.mem_wait;

endmodule

// File: tb/tb_vscale_mem_arbiter.sv
// tb_vscale_mem_arbiter
// Scoreboard bench for vscale_mem_arbiter. Each scenario task drives one cycle
// of stimulus and queues the outputs it expects for that cycle. It then pops
// and compares those expectations on the falling edge, or a few ns after an
// asynchronous reset event.
module tb_vscale_mem_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  vscale_mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  vscale_mem_arbiter dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef enum int {
    S_MEM_EN, S_MEM_WEN, S_MEM_SIZE, S_MEM_ADDR, S_MEM_WDATA,
    S_IWAIT, S_DWAIT, S_IBAD, S_DBAD, S_IRDATA, S_DRDATA
  } sig_e;

  typedef struct {
    string       name;
    sig_e        sig;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];

  function automatic logic [31:0] sample(sig_e s);
    case (s)
      S_MEM_EN:    sample = {31'd0, bus.mem_en};
      S_MEM_WEN:   sample = {31'd0, bus.mem_wen};
      S_MEM_SIZE:  sample = {29'd0, bus.mem_size};
      S_MEM_ADDR:  sample = bus.mem_addr;
      S_MEM_WDATA: sample = bus.mem_wdata;
      S_IWAIT:     sample = {31'd0, bus.imem_wait};
      S_DWAIT:     sample = {31'd0, bus.dmem_wait};
      S_IBAD:      sample = {31'd0, bus.imem_badmem_e};
      S_DBAD:      sample = {31'd0, bus.dmem_badmem_e};
      S_IRDATA:    sample = bus.imem_rdata;
      S_DRDATA:    sample = bus.dmem_rdata;
      default:     sample = '0;
    endcase
  endfunction

  task automatic want(input string name, input sig_e s, input logic [31:0] v);
    exp_t e;
    e.name = name;
    e.sig  = s;
    e.exp  = v;
    sb.push_back(e);
  endtask

  task automatic idle_inputs();
    bus.imem_en            = 1'b0;
    bus.imem_addr          = '0;
    bus.dmem_en            = 1'b0;
    bus.dmem_wen           = 1'b0;
    bus.dmem_size          = 3'b010;
    bus.dmem_addr          = '0;
    bus.dmem_wdata_delayed = '0;
    bus.mem_rdata          = '0;
    bus.mem_wait           = 1'b0;
    bus.mem_badmem_e       = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    logic [31:0] got;
    idle_inputs();
    reset = 1'b0;
    next_cycle();
    bus.imem_en = 1'b1;
    bus.dmem_en = 1'b1;
    bus.dmem_wen = 1'b1;
    bus.mem_badmem_e = 1'b1;
    bus.mem_wait = 1'b1;
    want("rst_mem_en", S_MEM_EN, 32'd0);
    want("rst_mem_wen", S_MEM_WEN, 32'd0);
    want("rst_imem_wait", S_IWAIT, 32'd0);
    want("rst_dmem_wait", S_DWAIT, 32'd0);
    want("rst_imem_bad", S_IBAD, 32'd0);
    want("rst_dmem_bad", S_DBAD, 32'd0);
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      vectors++;
      got = sample(e.sig);
      if (got !== e.exp) begin
        miscompares++;
        $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
      end
    end
    next_cycle();
    idle_inputs();
    reset = 1'b1;
  endtask

  task automatic test_single_fetch();
    exp_t e;
    logic [31:0] got;
    for (int c = 0; c < 2; c++) begin
      idle_inputs();
      if (c == 0) begin
        bus.imem_en = 1'b1;
        bus.imem_addr = 32'h100;
        want("fetch_mem_en", S_MEM_EN, 32'd1);
        want("fetch_mem_addr", S_MEM_ADDR, 32'h100);
        want("fetch_mem_wen", S_MEM_WEN, 32'd0);
        want("fetch_mem_size", S_MEM_SIZE, 32'd2);
        want("fetch_ap_imem_wait", S_IWAIT, 32'd0);
      end else begin
        bus.mem_rdata = 32'h0000_0013;
        want("fetch_rdata", S_IRDATA, 32'h0000_0013);
        want("fetch_dp_imem_wait", S_IWAIT, 32'd0);
        want("fetch_dp_mem_en", S_MEM_EN, 32'd0);
        want("fetch_dp_ibad", S_IBAD, 32'd0);
      end
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        vectors++;
        got = sample(e.sig);
        if (got !== e.exp) begin
          miscompares++;
          $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_contest();
    exp_t e;
    logic [31:0] got;
    for (int c = 0; c < 3; c++) begin
      idle_inputs();
      case (c)
        0: begin
          bus.imem_en = 1'b1;
          bus.imem_addr = 32'h200;
          bus.dmem_en = 1'b1;
          bus.dmem_addr = 32'h8000;
          want("contest_mem_addr", S_MEM_ADDR, 32'h8000);
          want("contest_mem_en", S_MEM_EN, 32'd1);
          want("contest_imem_wait0", S_IWAIT, 32'd0);
        end
        1: begin
          bus.imem_en = 1'b1;
          bus.imem_addr = 32'h200;
          bus.mem_rdata = 32'h0000_1234;
          want("contest_loser_wait", S_IWAIT, 32'd1);
          want("contest_winner_wait", S_DWAIT, 32'd0);
          want("contest_refetch_addr", S_MEM_ADDR, 32'h200);
          want("contest_refetch_en", S_MEM_EN, 32'd1);
          want("contest_load_rdata", S_DRDATA, 32'h0000_1234);
        end
        default: begin
          bus.mem_rdata = 32'h0000_0093;
          want("contest_refetch_wait", S_IWAIT, 32'd0);
          want("contest_refetch_rdata", S_IRDATA, 32'h0000_0093);
          want("contest_idle_en", S_MEM_EN, 32'd0);
        end
      endcase
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        vectors++;
        got = sample(e.sig);
        if (got !== e.exp) begin
          miscompares++;
          $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_store_wait();
    exp_t e;
    logic [31:0] got;
    for (int c = 0; c < 5; c++) begin
      idle_inputs();
      if (c <= 2) begin
        bus.dmem_en = 1'b1;
        bus.dmem_wen = 1'b1;
        bus.dmem_addr = 32'h8004;
      end
      if (c >= 1) begin
        bus.imem_en = (c <= 3);
        bus.imem_addr = 32'h300;
        bus.dmem_wdata_delayed = 32'hDEAD_BEEF;
      end
      bus.mem_wait = (c == 1 || c == 2);
      case (c)
        0: begin
          want("st_ap_wen", S_MEM_WEN, 32'd1);
          want("st_ap_addr", S_MEM_ADDR, 32'h8004);
          want("st_ap_wdata", S_MEM_WDATA, 32'd0);
        end
        1, 2: begin
          want("st_stall_dwait", S_DWAIT, 32'd1);
          want("st_stall_iwait", S_IWAIT, 32'd0);
          want("st_stall_wdata", S_MEM_WDATA, 32'hDEAD_BEEF);
          want("st_stall_addr_held", S_MEM_ADDR, 32'h8004);
          want("st_stall_wen_held", S_MEM_WEN, 32'd1);
          want("st_stall_en_held", S_MEM_EN, 32'd1);
        end
        3: begin
          want("st_done_dwait", S_DWAIT, 32'd0);
          want("st_done_wdata", S_MEM_WDATA, 32'hDEAD_BEEF);
          want("st_next_fetch_addr", S_MEM_ADDR, 32'h300);
          want("st_next_fetch_wen", S_MEM_WEN, 32'd0);
        end
        default: begin
          want("st_wdata_gated", S_MEM_WDATA, 32'd0);
          want("st_fetch_dp_iwait", S_IWAIT, 32'd0);
        end
      endcase
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        vectors++;
        got = sample(e.sig);
        if (got !== e.exp) begin
          miscompares++;
          $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_badmem();
    exp_t e;
    logic [31:0] got;
    for (int c = 0; c < 6; c++) begin
      idle_inputs();
      case (c)
        0: begin
          bus.imem_en = 1'b1;
          bus.imem_addr = 32'h400;
        end
        1: begin
          bus.mem_badmem_e = 1'b1;
          want("bad_fetch_ibad", S_IBAD, 32'd1);
          want("bad_fetch_dbad", S_DBAD, 32'd0);
        end
        2: begin
          bus.dmem_en = 1'b1;
          bus.dmem_addr = 32'h8008;
          bus.mem_badmem_e = 1'b1;
          want("bad_noowner_ibad", S_IBAD, 32'd0);
          want("bad_noowner_dbad", S_DBAD, 32'd0);
        end
        3: begin
          bus.mem_badmem_e = 1'b1;
          bus.mem_wait = 1'b1;
          want("bad_wait_dbad", S_DBAD, 32'd0);
          want("bad_wait_dwait", S_DWAIT, 32'd1);
        end
        4: begin
          bus.mem_badmem_e = 1'b1;
          want("bad_load_dbad", S_DBAD, 32'd1);
          want("bad_load_ibad", S_IBAD, 32'd0);
        end
        default: ;
      endcase
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        vectors++;
        got = sample(e.sig);
        if (got !== e.exp) begin
          miscompares++;
          $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
        end
      end
      next_cycle();
    end
  endtask

  // Both requesters stay active. In the fairness build, every fifth grant goes
  // to imem. In the default build, dmem takes every grant.
  task automatic test_fairness();
    exp_t e;
    logic [31:0] got;
    logic prev_imem, imem_turn;
    prev_imem = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      idle_inputs();
`ifdef VSCALE_MEM_ARB_FAIRNESS_EN
      imem_turn = ((k % 5) == 4);
`else
      imem_turn = 1'b0;
`endif
      if (k < 10) begin
        bus.imem_en = 1'b1;
        bus.imem_addr = 32'h500;
        bus.dmem_en = 1'b1;
        bus.dmem_addr = 32'h9000;
        want($sformatf("fair_grant_%0d", k), S_MEM_ADDR, imem_turn ? 32'h500 : 32'h9000);
      end
      want($sformatf("fair_iwait_%0d", k), S_IWAIT, {31'd0, (k > 0) && !prev_imem});
      want($sformatf("fair_dwait_%0d", k), S_DWAIT, {31'd0, (k > 0) && prev_imem});
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        vectors++;
        got = sample(e.sig);
        if (got !== e.exp) begin
          miscompares++;
          $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
        end
      end
      prev_imem = imem_turn;
      next_cycle();
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    logic [31:0] got;
    for (int c = 0; c < 6; c++) begin
      case (c)
        0: begin
          idle_inputs();
          bus.dmem_en = 1'b1;
          bus.dmem_addr = 32'h8010;
        end
        1: begin
          idle_inputs();
          bus.mem_wait = 1'b1;
          want("rmid_dwait_before", S_DWAIT, 32'd1);
        end
        2: begin
          #1;
          reset = 1'b0;
          bus.imem_en = 1'b1;
          bus.dmem_en = 1'b1;
          #1;
          want("rmid_dwait_abandon", S_DWAIT, 32'd0);
          want("rmid_mem_en", S_MEM_EN, 32'd0);
          want("rmid_iwait", S_IWAIT, 32'd0);
        end
        3: begin
          bus.mem_wait = 1'b0;
          bus.mem_badmem_e = 1'b1;
          #1;
          want("rmid_dbad", S_DBAD, 32'd0);
          want("rmid_ibad", S_IBAD, 32'd0);
        end
        4: begin
          idle_inputs();
          reset = 1'b1;
          bus.imem_en = 1'b1;
          bus.imem_addr = 32'h600;
          want("rmid_first_en", S_MEM_EN, 32'd1);
          want("rmid_first_addr", S_MEM_ADDR, 32'h600);
          want("rmid_rel_dwait", S_DWAIT, 32'd0);
        end
        default: begin
          idle_inputs();
          bus.mem_rdata = 32'h0000_600D;
          want("rmid_first_rdata", S_IRDATA, 32'h0000_600D);
          want("rmid_first_iwait", S_IWAIT, 32'd0);
        end
      endcase
      if (c != 2 && c != 3) @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        vectors++;
        got = sample(e.sig);
        if (got !== e.exp) begin
          miscompares++;
          $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
        end
      end
      if (c != 2) next_cycle();
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_fetch();
    test_contest();
    test_store_wait();
    test_badmem();
    test_fairness();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
